// File: rtl/div_issue_ctrl_if.sv
// Bundle of the EXE request/response handshake and both AXI-Stream divider IP channels.
// The master modport is the controller view; slave is the EXE/IP environment view.
interface div_issue_ctrl_if;
  logic        req_valid;
  logic        req_signed;
  logic        req_mod;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_ack;
  logic        cancel;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        busy;
  logic [31:0] div_dividend_tdata;
  logic [31:0] div_divisor_tdata;
  logic        sdiv_dividend_tvalid;
  logic        sdiv_dividend_tready;
  logic        sdiv_divisor_tvalid;
  logic        sdiv_divisor_tready;
  logic        sdiv_dout_tvalid;
  logic [63:0] sdiv_dout_tdata;
  logic        udiv_dividend_tvalid;
  logic        udiv_dividend_tready;
  logic        udiv_divisor_tvalid;
  logic        udiv_divisor_tready;
  logic        udiv_dout_tvalid;
  logic [63:0] udiv_dout_tdata;

  modport master (
    input  req_valid, req_signed, req_mod, req_src1, req_src2, req_ack, cancel,
    output resp_valid, resp_result, busy, div_dividend_tdata, div_divisor_tdata,
    output sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid,
    input  sdiv_dividend_tready, sdiv_divisor_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
    input  udiv_dividend_tready, udiv_divisor_tready, udiv_dout_tvalid, udiv_dout_tdata
  );

  modport slave (
    output req_valid, req_signed, req_mod, req_src1, req_src2, req_ack, cancel,
    input  resp_valid, resp_result, busy, div_dividend_tdata, div_divisor_tdata,
    input  sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid,
    output sdiv_dividend_tready, sdiv_divisor_tready, sdiv_dout_tvalid, sdiv_dout_tdata,
    output udiv_dividend_tready, udiv_divisor_tready, udiv_dout_tvalid, udiv_dout_tdata
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/wait/hold sequencer for the EXE-stage divide path (signed and unsigned AXIS divider IPs).
// Optional feature macro: DIV_ZERO_BYPASS_EN (answer x/0 and x%0 locally without the IP).
module div_issue_ctrl (
  input logic              clk_i,
  input logic              rst_i,
  div_issue_ctrl_if.master div_io
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q;
  logic        signed_q;
  logic        mod_q;
  logic        drain_q;
  logic        busy_q;
  logic        resp_valid_q;
  logic [31:0] resp_result_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic        s_dend_tvalid_q;
  logic        s_dsor_tvalid_q;
  logic        u_dend_tvalid_q;
  logic        u_dsor_tvalid_q;

  logic        dend_tvalid_s;
  logic        dsor_tvalid_s;
  logic        dend_tready_s;
  logic        dsor_tready_s;
  logic        dout_tvalid_s;
  logic [63:0] dout_tdata_s;
  logic        dend_tvalid_d;
  logic        dsor_tvalid_d;
  logic        drain_d;
  logic [31:0] result_s;

  // Only the IP chosen at accept time is ever looked at; the other one is ignored completely.
  assign dend_tvalid_s = signed_q ? s_dend_tvalid_q : u_dend_tvalid_q;
  assign dsor_tvalid_s = signed_q ? s_dsor_tvalid_q : u_dsor_tvalid_q;
  assign dend_tready_s = signed_q ? div_io.sdiv_dividend_tready : div_io.udiv_dividend_tready;
  assign dsor_tready_s = signed_q ? div_io.sdiv_divisor_tready : div_io.udiv_divisor_tready;
  assign dout_tvalid_s = signed_q ? div_io.sdiv_dout_tvalid : div_io.udiv_dout_tvalid;
  assign dout_tdata_s  = signed_q ? div_io.sdiv_dout_tdata : div_io.udiv_dout_tdata;
  assign dend_tvalid_d = dend_tvalid_s & ~dend_tready_s;
  assign dsor_tvalid_d = dsor_tvalid_s & ~dsor_tready_s;
  assign drain_d       = drain_q | div_io.cancel;
  assign result_s      = mod_q ? dout_tdata_s[31:0] : dout_tdata_s[63:32];

  // Sequencer: tvalid registers double as the "not yet sent" flags while in ISSUE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      signed_q        <= 1'b0;
      mod_q           <= 1'b0;
      drain_q         <= 1'b0;
      busy_q          <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_result_q   <= 32'h0;
      dividend_q      <= 32'h0;
      divisor_q       <= 32'h0;
      s_dend_tvalid_q <= 1'b0;
      s_dsor_tvalid_q <= 1'b0;
      u_dend_tvalid_q <= 1'b0;
      u_dsor_tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          drain_q <= 1'b0;
          if (div_io.req_valid && !div_io.cancel) begin
            dividend_q <= div_io.req_src1;
            divisor_q  <= div_io.req_src2;
            signed_q   <= div_io.req_signed;
            mod_q      <= div_io.req_mod;
            busy_q     <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            if (div_io.req_src2 == 32'h0) begin
              state_q       <= DONE;
              resp_valid_q  <= 1'b1;
              resp_result_q <= div_io.req_mod ? div_io.req_src1 : 32'h0;
            end else
`endif
            begin
              state_q         <= ISSUE;
              s_dend_tvalid_q <= div_io.req_signed;
              s_dsor_tvalid_q <= div_io.req_signed;
              u_dend_tvalid_q <= ~div_io.req_signed;
              u_dsor_tvalid_q <= ~div_io.req_signed;
            end
          end
        end
        ISSUE: begin
          // Cancel only marks the op for draining; in-flight tvalids must still complete.
          drain_q         <= drain_d;
          s_dend_tvalid_q <= signed_q & dend_tvalid_d;
          s_dsor_tvalid_q <= signed_q & dsor_tvalid_d;
          u_dend_tvalid_q <= ~signed_q & dend_tvalid_d;
          u_dsor_tvalid_q <= ~signed_q & dsor_tvalid_d;
          if (!dend_tvalid_d && !dsor_tvalid_d) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          drain_q <= drain_d;
          if (dout_tvalid_s) begin
            if (drain_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q       <= DONE;
              resp_valid_q  <= 1'b1;
              resp_result_q <= result_s;
            end
          end
        end
        DONE: begin
          if (div_io.req_ack || div_io.cancel) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_io.resp_valid           = resp_valid_q;
  assign div_io.resp_result          = resp_result_q;
  assign div_io.busy                 = busy_q;
  assign div_io.div_dividend_tdata   = dividend_q;
  assign div_io.div_divisor_tdata    = divisor_q;
  assign div_io.sdiv_dividend_tvalid = s_dend_tvalid_q;
  assign div_io.sdiv_divisor_tvalid  = s_dsor_tvalid_q;
  assign div_io.udiv_dividend_tvalid = u_dend_tvalid_q;
  assign div_io.udiv_divisor_tvalid  = u_dsor_tvalid_q;
endmodule
